// File: rtl/dafx_stereo_mixer.sv
// N-channel stereo mixer: per-channel Q-format gain and linear pan, master gain with saturation,
// sticky clip flags and peak meters. One channel MAC per clock; frames are processed one at a time.
module dafx_stereo_mixer #(
  parameter int NR_OF_CHANNELS_P = 4,
  parameter int AUDIO_WIDTH_P    = 24,
  parameter int GAIN_WIDTH_P     = 32,
  parameter int Q_BITS_P         = 16,
  parameter int PAN_WIDTH_P      = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NR_OF_CHANNELS_P*AUDIO_WIDTH_P-1:0] channel_data,
  input  logic                                      channel_valid,
  output logic                                      channel_ready,
  output logic [AUDIO_WIDTH_P-1:0]                  out_left,
  output logic [AUDIO_WIDTH_P-1:0]                  out_right,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  input  logic [NR_OF_CHANNELS_P*GAIN_WIDTH_P-1:0]  cr_channel_gain,
  input  logic [NR_OF_CHANNELS_P*PAN_WIDTH_P-1:0]   cr_channel_pan,
  input  logic [GAIN_WIDTH_P-1:0]                   cr_output_gain,
  input  logic                                      cmd_clear,
  output logic [NR_OF_CHANNELS_P-1:0]               sr_channel_clip,
  output logic                                      sr_out_clip,
  output logic [AUDIO_WIDTH_P-1:0]                  sr_peak_left,
  output logic [AUDIO_WIDTH_P-1:0]                  sr_peak_right
);
  localparam int N    = NR_OF_CHANNELS_P;
  localparam int AW   = AUDIO_WIDTH_P;
  localparam int GW   = GAIN_WIDTH_P;
  localparam int PW   = PAN_WIDTH_P;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam int ACCW = AW + $clog2(N) + 1;
  localparam int CPW  = AW + GW;
  localparam int PPW  = AW + PW + 2;
  localparam int MPW  = ACCW + GW;
  localparam logic signed [AW-1:0] SAT_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {1'b1, {(AW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, GAIN, OUT} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]             ch_cnt;
  logic [N*AW-1:0]           data_q;
  logic [N*GW-1:0]           gain_q;
  logic [N*PW-1:0]           pan_q;
  logic signed [GW-1:0]      og_q;
  logic signed [ACCW-1:0]    acc_l, acc_r;

  logic signed [AW-1:0]      x_sel;
  logic signed [GW-1:0]      g_sel;
  logic [PW-1:0]             p_sel;
  logic signed [CPW-1:0]     ch_prod, ch_shift;
  logic                      ch_sat;
  logic signed [AW-1:0]      s_val;
  logic [PW:0]               wl_u;
  logic signed [PW+1:0]      wl, wr;
  logic signed [PPW-1:0]     prod_l, prod_r, sh_l, sh_r;
  logic signed [MPW-1:0]     m_prod_l, m_prod_r, m_sh_l, m_sh_r;
  logic                      m_sat_l, m_sat_r;
  logic signed [AW-1:0]      m_l, m_r;
  logic [AW-1:0]             mag_l, mag_r;
  logic                      accept, handshake;

  assign accept    = (state == IDLE) && channel_valid && channel_ready;
  assign handshake = (state == OUT) && out_valid && out_ready;

  // Channel step: gain with saturation, then linear pan split.
  assign x_sel    = data_q[ch_cnt*AW +: AW];
  assign g_sel    = gain_q[ch_cnt*GW +: GW];
  assign p_sel    = pan_q[ch_cnt*PW +: PW];
  assign ch_prod  = x_sel * g_sel;
  assign ch_shift = ch_prod >>> Q_BITS_P;
  assign ch_sat   = !((&ch_shift[CPW-1:AW-1]) || !(|ch_shift[CPW-1:AW-1]));
  assign s_val    = ch_sat ? (ch_shift[CPW-1] ? SAT_MIN : SAT_MAX) : ch_shift[AW-1:0];
  assign wl_u     = {1'b1, {PW{1'b0}}} - {1'b0, p_sel};
  assign wl       = $signed({1'b0, wl_u});
  assign wr       = $signed({2'b00, p_sel});
  assign prod_l   = s_val * wl;
  assign prod_r   = s_val * wr;
  assign sh_l     = prod_l >>> PW;
  assign sh_r     = prod_r >>> PW;

  // Master step.
  assign m_prod_l = acc_l * og_q;
  assign m_prod_r = acc_r * og_q;
  assign m_sh_l   = m_prod_l >>> Q_BITS_P;
  assign m_sh_r   = m_prod_r >>> Q_BITS_P;
  assign m_sat_l  = !((&m_sh_l[MPW-1:AW-1]) || !(|m_sh_l[MPW-1:AW-1]));
  assign m_sat_r  = !((&m_sh_r[MPW-1:AW-1]) || !(|m_sh_r[MPW-1:AW-1]));
  assign m_l      = m_sat_l ? (m_sh_l[MPW-1] ? SAT_MIN : SAT_MAX) : m_sh_l[AW-1:0];
  assign m_r      = m_sat_r ? (m_sh_r[MPW-1] ? SAT_MIN : SAT_MAX) : m_sh_r[AW-1:0];

  // The most negative sample reads back as full-scale positive.
  assign mag_l = (out_left == SAT_MIN) ? SAT_MAX : (out_left[AW-1] ? (~out_left + 1'b1) : out_left);
  assign mag_r = (out_right == SAT_MIN) ? SAT_MAX : (out_right[AW-1] ? (~out_right + 1'b1) : out_right);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MAC; else state_nxt = IDLE;
      MAC:     if (ch_cnt == CW'(N-1)) state_nxt = GAIN; else state_nxt = MAC;
      GAIN:    state_nxt = OUT;
      OUT:     if (handshake) state_nxt = IDLE; else state_nxt = OUT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      channel_ready <= 1'b0;
      out_valid     <= 1'b0;
    end else begin
      state         <= state_nxt;
      channel_ready <= (state_nxt == IDLE);
      out_valid     <= (state_nxt == OUT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_cnt    <= '0;
      data_q    <= '0;
      gain_q    <= '0;
      pan_q     <= '0;
      og_q      <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      out_left  <= '0;
      out_right <= '0;
    end else begin
      if (accept) begin
        data_q <= channel_data;
        gain_q <= cr_channel_gain;
        pan_q  <= cr_channel_pan;
        og_q   <= cr_output_gain;
        acc_l  <= '0;
        acc_r  <= '0;
        ch_cnt <= '0;
      end else if (state == MAC) begin
        acc_l <= acc_l + $signed(sh_l[ACCW-1:0]);
        acc_r <= acc_r + $signed(sh_r[ACCW-1:0]);
        if (ch_cnt != CW'(N-1)) ch_cnt <= ch_cnt + CW'(1);
      end else if (state == GAIN) begin
        out_left  <= m_l;
        out_right <= m_r;
      end
    end
  end

  // Status: a clear and a new event in the same cycle leave the new event recorded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_channel_clip <= '0;
      sr_out_clip     <= 1'b0;
      sr_peak_left    <= '0;
      sr_peak_right   <= '0;
    end else begin
      if (cmd_clear) begin
        sr_channel_clip <= '0;
        sr_out_clip     <= 1'b0;
        sr_peak_left    <= '0;
        sr_peak_right   <= '0;
      end
      if (state == MAC && ch_sat) sr_channel_clip[ch_cnt] <= 1'b1;
      if (state == GAIN && (m_sat_l || m_sat_r)) sr_out_clip <= 1'b1;
      if (handshake) begin
        if (cmd_clear || mag_l > sr_peak_left)  sr_peak_left  <= mag_l;
        if (cmd_clear || mag_r > sr_peak_right) sr_peak_right <= mag_r;
      end
    end
  end
endmodule

// File: tb/tb_dafx_stereo_mixer.sv
// Directed self-checking bench for dafx_stereo_mixer (N=4, AW=24, GW=32, Q=16, PW=8).
module tb_dafx_stereo_mixer;
  logic         clk = 1'b0;
  logic         rst;
  logic [95:0]  channel_data;
  logic         channel_valid;
  logic         channel_ready;
  logic [23:0]  out_left, out_right;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] cr_channel_gain;
  logic [31:0]  cr_channel_pan;
  logic [31:0]  cr_output_gain;
  logic         cmd_clear;
  logic [3:0]   sr_channel_clip;
  logic         sr_out_clip;
  logic [23:0]  sr_peak_left, sr_peak_right;

  logic [23:0]  cd [4];
  logic [31:0]  cg [4];
  logic [7:0]   cp [4];
  logic [23:0]  ol, orr;
  int           lat;
  int           tests = 0;
  int           fails = 0;

  dafx_stereo_mixer dut (
    .clk(clk), .rst(rst), .channel_data(channel_data), .channel_valid(channel_valid),
    .channel_ready(channel_ready), .out_left(out_left), .out_right(out_right),
    .out_valid(out_valid), .out_ready(out_ready), .cr_channel_gain(cr_channel_gain),
    .cr_channel_pan(cr_channel_pan), .cr_output_gain(cr_output_gain), .cmd_clear(cmd_clear),
    .sr_channel_clip(sr_channel_clip), .sr_out_clip(sr_out_clip),
    .sr_peak_left(sr_peak_left), .sr_peak_right(sr_peak_right)
  );

  always #5 clk = ~clk;

  always_comb begin
    channel_data    = '0;
    cr_channel_gain = '0;
    cr_channel_pan  = '0;
    for (int i = 0; i < 4; i++) begin
      channel_data[i*24 +: 24]    = cd[i];
      cr_channel_gain[i*32 +: 32] = cg[i];
      cr_channel_pan[i*8 +: 8]    = cp[i];
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic zero_ch();
    for (int i = 0; i < 4; i++) begin
      cd[i] = 24'd0; cg[i] = 32'd0; cp[i] = 8'd0;
    end
  endtask

  task automatic start_frame();
    @(negedge clk);
    channel_valid = 1'b1;
    for (int i = 0; i < 50 && !channel_ready; i++) @(negedge clk);
    if (!channel_ready) chk("accept_timeout", {63'd0, channel_ready}, 64'd1);
    @(posedge clk);
    #1 channel_valid = 1'b0;
  endtask

  task automatic finish_frame(input logic clr_at_hs);
    lat = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) chk("out_timeout", {63'd0, out_valid}, 64'd1);
    ol  = out_left;
    orr = out_right;
    if (out_ready) begin
      if (clr_at_hs) cmd_clear = 1'b1;
      @(posedge clk);
      #1 cmd_clear = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic run_frame();
    start_frame();
    finish_frame(1'b0);
  endtask

  initial begin
    rst = 1'b1; channel_valid = 1'b0; out_ready = 1'b1; cmd_clear = 1'b0;
    cr_output_gain = 32'h0001_0000;
    zero_ch();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {63'd0, channel_ready}, 64'd0);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_left", {40'd0, out_left}, 64'd0);
    chk("rst_clip", {60'd0, sr_channel_clip}, 64'd0);
    rst = 1'b0;

    // single channel hard left, latency
    cd[0] = 24'd1000; cg[0] = 32'h0001_0000;
    run_frame();
    chk("t1_latency", 64'(lat), 64'd6);
    chk("t1_left", {40'd0, ol}, 64'd1000);
    chk("t1_right", {40'd0, orr}, 64'd0);
    chk("t1_peak_l", {40'd0, sr_peak_left}, 64'd1000);

    // four channels centre pan
    for (int i = 0; i < 4; i++) begin
      cd[i] = 24'h10_0000; cg[i] = 32'h0001_0000; cp[i] = 8'd128;
    end
    run_frame();
    chk("t2_left", {40'd0, ol}, 64'h20_0000);
    chk("t2_right", {40'd0, orr}, 64'h20_0000);
    chk("t2_clip", {59'd0, sr_out_clip, sr_channel_clip}, 64'd0);
    chk("t2_peak_r", {40'd0, sr_peak_right}, 64'h20_0000);

    // floor shift of a negative sample
    zero_ch();
    cd[0] = 24'hFF_FFFF; cg[0] = 32'h0001_0000; cp[0] = 8'd128;
    run_frame();
    chk("floor_left", {40'd0, ol}, 64'hFF_FFFF);
    chk("floor_right", {40'd0, orr}, 64'hFF_FFFF);

    // channel clip on ch1
    zero_ch();
    cd[1] = 24'h40_0000; cg[1] = 32'h0002_0000;
    run_frame();
    chk("t3_left", {40'd0, ol}, 64'h7F_FFFF);
    chk("t3_right", {40'd0, orr}, 64'd0);
    chk("t3_clip", {60'd0, sr_channel_clip}, 64'b0010);
    chk("t3_oclip", {63'd0, sr_out_clip}, 64'd0);

    // output clip from two channels
    zero_ch();
    cd[0] = 24'h60_0000; cg[0] = 32'h0001_0000;
    cd[1] = 24'h60_0000; cg[1] = 32'h0001_0000;
    run_frame();
    chk("t4_left", {40'd0, ol}, 64'h7F_FFFF);
    chk("t4_oclip", {63'd0, sr_out_clip}, 64'd1);
    chk("t4_peak_l", {40'd0, sr_peak_left}, 64'h7F_FFFF);
    chk("t4_clip_sticky", {60'd0, sr_channel_clip}, 64'b0010);

    // negative saturation, most negative output
    zero_ch();
    cd[0] = 24'h80_0000; cg[0] = 32'h0002_0000;
    run_frame();
    chk("nsat_left", {40'd0, ol}, 64'h80_0000);
    chk("nsat_clip", {60'd0, sr_channel_clip}, 64'b0011);
    chk("nsat_peak_l", {40'd0, sr_peak_left}, 64'h7F_FFFF);

    // clear
    @(negedge clk); cmd_clear = 1'b1;
    @(negedge clk); cmd_clear = 1'b0;
    chk("clr_flags", {59'd0, sr_out_clip, sr_channel_clip}, 64'd0);
    chk("clr_peak_l", {40'd0, sr_peak_left}, 64'd0);

    // gain 0.5, pan 64, master 2; cr changes mid-frame ignored
    zero_ch();
    cd[0] = 24'hFF_FC18; cg[0] = 32'h0000_8000; cp[0] = 8'd64;
    cr_output_gain = 32'h0002_0000;
    start_frame();
    cg[0] = 32'd0; cr_output_gain = 32'd0;
    finish_frame(1'b0);
    chk("pan_left", {40'd0, ol}, 64'hFF_FD12);
    chk("pan_right", {40'd0, orr}, 64'hFF_FF06);
    chk("pan_peak_l", {40'd0, sr_peak_left}, 64'd750);
    chk("pan_peak_r", {40'd0, sr_peak_right}, 64'd250);
    cr_output_gain = 32'h0001_0000;

    // backpressure: held output, new frame waits and is not lost
    zero_ch();
    cd[0] = 24'd1000; cg[0] = 32'h0001_0000;
    out_ready = 1'b0;
    start_frame();
    finish_frame(1'b0);
    cd[0] = 24'd2000;
    channel_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_left", {40'd0, out_left}, 64'd1000);
      chk("bp_ready", {63'd0, channel_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 20 && !channel_ready; i++) @(negedge clk);
    @(posedge clk);
    #1 channel_valid = 1'b0;
    finish_frame(1'b0);
    chk("bp_next_left", {40'd0, ol}, 64'd2000);

    // reset in the middle of MAC
    cd[0] = 24'd5000;
    start_frame();
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mrst_ready", {63'd0, channel_ready}, 64'd0);
    chk("mrst_valid", {63'd0, out_valid}, 64'd0);
    chk("mrst_left", {40'd0, out_left}, 64'd0);
    chk("mrst_peak", {40'd0, sr_peak_left}, 64'd0);
    @(negedge clk); rst = 1'b0;
    cd[0] = 24'd1000;
    run_frame();
    chk("mrst_after", {40'd0, ol}, 64'd1000);

    // clear in the same cycle as a channel clip
    zero_ch();
    cd[1] = 24'h40_0000; cg[1] = 32'h0002_0000;
    run_frame();
    chk("cc_pre", {60'd0, sr_channel_clip}, 64'b0010);
    zero_ch();
    cd[0] = 24'h40_0000; cg[0] = 32'h0002_0000;
    start_frame();
    cmd_clear = 1'b1;
    @(posedge clk);
    #1 cmd_clear = 1'b0;
    finish_frame(1'b0);
    chk("cc_clip", {60'd0, sr_channel_clip}, 64'b0001);
    chk("cc_left", {40'd0, ol}, 64'h7F_FFFF);

    // clear in the same cycle as a peak update
    zero_ch();
    cd[0] = 24'd1000; cg[0] = 32'h0001_0000;
    start_frame();
    finish_frame(1'b1);
    chk("pc_peak_l", {40'd0, sr_peak_left}, 64'd1000);
    chk("pc_peak_r", {40'd0, sr_peak_right}, 64'd0);
    chk("pc_clip", {60'd0, sr_channel_clip}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
